// File: rtl/motion_update_broadcast.sv
// motion_update_broadcast: computes each updated particle's destination cell and broadcasts it to all
// per-cell caches inside a framed motion_update_enable window. Define PERIODIC_WRAP_EN for periodic wrap.
module motion_update_broadcast #(
    parameter int DATA_WIDTH    = 32,
    parameter int FRAC_BITS     = 24,
    parameter int CELL_ID_WIDTH = 4,
    parameter int CELL_NUM_X    = 3,
    parameter int CELL_NUM_Y    = 3,
    parameter int CELL_NUM_Z    = 3,
    parameter int CNT_WIDTH     = 16,
    parameter int HOLD_CYCLES   = 2   // must be >= 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_start,
    input  logic [3*DATA_WIDTH-1:0]    in_pos,
    input  logic                       in_valid,
    input  logic                       in_last,
    output logic                       in_ready,
    output logic                       motion_update_enable,
    output logic [3*DATA_WIDTH-1:0]    out_data,
    output logic [3*CELL_ID_WIDTH-1:0] out_dst_cell,
    output logic                       out_data_valid,
    output logic [CNT_WIDTH-1:0]       out_particle_cnt,
    output logic                       out_done,
    output logic                       out_err
);
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, STREAM, FLUSH, HOLD, DONE} state_t;

    state_t                      state;
    logic [HOLD_W-1:0]           hold_cnt;
    logic                        beat_ok;
    logic [3*DATA_WIDTH-1:0]     wrap_pos;
    logic [3*CELL_ID_WIDTH-1:0]  wrap_cell;
    logic signed [DATA_WIDTH-1:0] coord;
    int                          idx_i;

    function automatic int cell_num(input int unsigned axis);
        case (axis)
            0:       return CELL_NUM_X;
            1:       return CELL_NUM_Y;
            default: return CELL_NUM_Z;
        endcase
    endfunction

    assign in_ready = (state == STREAM);

    // Per-axis integer part is the signed bits above the binary point; cells are 1-based on output.
    always_comb begin
        beat_ok   = 1'b1;
        wrap_pos  = in_pos;
        wrap_cell = '0;
        coord     = '0;
        idx_i     = 0;
        for (int unsigned a = 0; a < 3; a++) begin
            coord = in_pos[a*DATA_WIDTH +: DATA_WIDTH];
            idx_i = int'($signed(coord[DATA_WIDTH-1:FRAC_BITS]));
`ifdef PERIODIC_WRAP_EN
            if (idx_i == cell_num(a)) begin
                coord = coord - (DATA_WIDTH'(cell_num(a)) << FRAC_BITS);
                idx_i = 0;
            end else if (idx_i == -1) begin
                coord = coord + (DATA_WIDTH'(cell_num(a)) << FRAC_BITS);
                idx_i = cell_num(a) - 1;
            end
`endif
            if (idx_i < 0 || idx_i >= cell_num(a))
                beat_ok = 1'b0;
            wrap_pos[a*DATA_WIDTH +: DATA_WIDTH]          = coord;
            wrap_cell[a*CELL_ID_WIDTH +: CELL_ID_WIDTH]   = CELL_ID_WIDTH'(idx_i + 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= IDLE;
            hold_cnt             <= '0;
            motion_update_enable <= 1'b0;
            out_data             <= '0;
            out_dst_cell         <= '0;
            out_data_valid       <= 1'b0;
            out_particle_cnt     <= '0;
            out_done             <= 1'b0;
            out_err              <= 1'b0;
        end else begin
            out_data_valid <= 1'b0;
            out_data       <= '0;
            out_dst_cell   <= '0;
            out_done       <= 1'b0;
            case (state)
                IDLE: if (in_start) begin
                    state                <= STREAM;
                    motion_update_enable <= 1'b1;
                    out_particle_cnt     <= '0;
                    out_err              <= 1'b0;
                end
                STREAM: if (in_valid) begin
                    if (beat_ok) begin
                        out_data_valid <= 1'b1;
                        out_data       <= wrap_pos;
                        out_dst_cell   <= wrap_cell;
                        if (out_particle_cnt != '1)
                            out_particle_cnt <= out_particle_cnt + 1'b1;
                    end else begin
                        out_err <= 1'b1;
                    end
                    if (in_last)
                        state <= FLUSH;
                end
                FLUSH: begin
                    state                <= HOLD;
                    motion_update_enable <= 1'b0;
                    hold_cnt             <= '0;
                end
                HOLD: begin
                    if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
                        state    <= DONE;
                        out_done <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
